// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage block for the SAD pipeline.
// Word-addressed data memory with READ_LAT-cycle registered reads, sized
// loads with sign/zero extension, sized stores, and writeback selection.
// Optional feature macro: MEM_BYTE_ENABLE_EN. When defined, the memory has
// per-lane write enables and byte/halfword stores finish like word stores.
// When undefined, byte/halfword stores are read-modify-write through WAIT
// and WRITE.
//
// Handshake: a request is taken on a rising edge when Req=1 and the FSM is
// in IDLE or RESP. All request inputs are latched on that edge. Stall is
// high while the unit cannot take a request (WAIT, WRITE). Done is a
// one-cycle pulse per request, and Result/AddrErr are valid while Done=1.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int READ_LAT   = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        unSigned,
  input  logic        MemtoReg,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] Result,
  output logic        Done,
  output logic        Stall,
  output logic        AddrErr,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam int         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [1:0] LAT_M1  = 2'(READ_LAT - 1);

  // Lanes touched by an access of size sz at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so any lane mask can pick it up.
  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   lane_data = {4{d[7:0]}};
      2'b01:   lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] be);
    lane_bits = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Select the addressed byte/half from a word and extend it.
  function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic uns,
                                           input logic [1:0] off, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   load_ext = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  logic [31:0]           mem [DEPTH];
  logic [31:0]           rd_pipe [READ_LAT];
  logic [31:0]           rd_data;
  logic [1:0]            state;
  logic [1:0]            cnt;
  logic                  wr_q;
  logic                  m2r_q;
  logic                  uns_q;
  logic [1:0]            size_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;

  logic                  accept;
  logic                  is_mem;
  logic                  misal;
  logic                  full_store;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [ADDR_WIDTH-1:0] q_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [3:0]            wr_be;
  logic [31:0]           wr_data;
  logic [31:0]           merge_mask;

  assign accept  = Req && (state == S_IDLE || state == S_RESP);
  assign is_mem  = MemRead || MemWrite;
  assign misal   = is_mem && (((Size == 2'b01) && Address[0]) ||
                              (Size[1] && (Address[1:0] != 2'b00)));
  assign acc_idx = Address[ADDR_WIDTH+1:2];
  assign q_idx   = addr_q[ADDR_WIDTH+1:2];
  assign rd_idx  = accept ? acc_idx : q_idx;
  assign rd_data = rd_pipe[READ_LAT-1];
  assign merge_mask = lane_bits(lane_mask(size_q, addr_q[1:0]));

`ifdef MEM_BYTE_ENABLE_EN
  assign full_store = 1'b1;
`else
  assign full_store = Size[1];
`endif

  assign Done      = (state == S_RESP);
  assign Stall     = (state == S_WAIT) || (state == S_WRITE);
  assign dbg_state = state;

  // Write port: immediate stores at accept, merged write-back in WRITE.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = acc_idx;
    wr_be   = 4'hf;
    wr_data = WriteData;
    if (state == S_WRITE) begin
      wr_en   = 1'b1;
      wr_idx  = q_idx;
      wr_data = (rd_data & ~merge_mask) | (lane_data(size_q, wdata_q) & merge_mask);
    end else if (accept && MemWrite && !misal && full_store) begin
      wr_en   = 1'b1;
`ifdef MEM_BYTE_ENABLE_EN
      wr_be   = lane_mask(Size, Address[1:0]);
`endif
      wr_data = lane_data(Size, WriteData);
    end
  end

  // Memory array: per-lane writes, never cleared, blocked while Reset is high.
  always_ff @(posedge Clk) begin
    if (!Reset && wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  // Registered read followed by READ_LAT-1 delay stages.
  always_ff @(posedge Clk) begin
    rd_pipe[0] <= mem[rd_idx];
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Access sequencer: accept/latch, latency count, write-back, response.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      cnt     <= 2'd0;
      Result  <= 32'd0;
      AddrErr <= 1'b0;
      wr_q    <= 1'b0;
      m2r_q   <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      wr_q    <= MemWrite;
      m2r_q   <= MemtoReg;
      uns_q   <= unSigned;
      size_q  <= Size;
      addr_q  <= Address;
      wdata_q <= WriteData;
      if (misal) begin
        state   <= S_RESP;
        Result  <= 32'd0;
        AddrErr <= 1'b1;
      end else if (!is_mem || (MemWrite && full_store)) begin
        state   <= S_RESP;
        Result  <= Address;
        AddrErr <= 1'b0;
      end else begin
        state   <= S_WAIT;
        cnt     <= LAT_M1;
        AddrErr <= 1'b0;
      end
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == 2'd0) begin
            if (wr_q) begin
              state <= S_WRITE;
            end else begin
              state  <= S_RESP;
              Result <= m2r_q ? load_ext(size_q, uns_q, addr_q[1:0], rd_data) : addr_q;
            end
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        S_WRITE: begin
          state  <= S_RESP;
          Result <= addr_q;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: scoreboard of expected responses, one entry
// pushed per tracked request and popped on every Done pulse.
module tb_mem_access_unit;
  localparam int AW  = 4;
  localparam int LAT = 2;
  localparam int W   = 41;
`ifdef MEM_BYTE_ENABLE_EN
  localparam int PLAT = 1;
  localparam int PSTL = 0;
  localparam logic [31:0] RST_LOAD = 32'h0000_1234;
`else
  localparam int PLAT = LAT + 2;
  localparam int PSTL = LAT + 1;
  localparam logic [31:0] RST_LOAD = 32'h0000_0000;
`endif

  // clock / reset
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset;
  logic        Req;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  Size;
  logic        unSigned;
  logic        MemtoReg;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] Result;
  logic        Done;
  logic        Stall;
  logic        AddrErr;
  logic [1:0]  dbg_state;

  mem_access_unit #(.ADDR_WIDTH(AW), .READ_LAT(LAT)) dut (
    .Clk(clk), .Reset(Reset), .Req(Req), .MemRead(MemRead), .MemWrite(MemWrite),
    .Size(Size), .unSigned(unSigned), .MemtoReg(MemtoReg), .Address(Address),
    .WriteData(WriteData), .Result(Result), .Done(Done), .Stall(Stall),
    .AddrErr(AddrErr), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stall_run = 0;
  // entry: {addr_err, latency[3:0], stall_cycles[3:0], result[31:0]}
  logic [W-1:0] exp_q[$];
  int acc_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard: compare every Done pulse against the oldest expectation
  always @(negedge clk) begin
    logic [W-1:0] e;
    int a;
    if (Reset) begin
      stall_run = 0;
    end else begin
      if (Stall) stall_run++;
      if (Done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", {31'b0, Done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("result", Result, e[31:0]);
          check("addr_err", {31'b0, AddrErr}, {31'b0, e[40]});
          check("latency", cyc - a + 1, {28'b0, e[39:36]});
          check("stall_cycles", stall_run, {28'b0, e[35:32]});
        end
        stall_run = 0;
      end
    end
  end

  // driver: present one request for one accept edge
  task automatic send(input logic mr, input logic mw, input logic [1:0] sz, input logic uns,
                      input logic m2r, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] res, input logic err, input int lat, input int stl,
                      input bit track);
    Req = 1'b1; MemRead = mr; MemWrite = mw; Size = sz; unSigned = uns;
    MemtoReg = m2r; Address = addr; WriteData = wd;
    if (track) begin
      exp_q.push_back({err, 4'(lat), 4'(stl), res});
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    Req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  task automatic ld(input logic [1:0] sz, input logic uns, input logic m2r,
                    input logic [31:0] addr, input logic [31:0] exp);
    wait_idle();
    send(1'b1, 1'b0, sz, uns, m2r, addr, 32'd0, exp, 1'b0, LAT + 1, LAT, 1'b1);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    wait_idle();
    if (sz[1]) send(1'b0, 1'b1, sz, 1'b0, 1'b0, addr, wd, addr, 1'b0, 1, 0, 1'b1);
    else       send(1'b0, 1'b1, sz, 1'b0, 1'b0, addr, wd, addr, 1'b0, PLAT, PSTL, 1'b1);
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = (off == 2'd2) ? w[31:16] : w[15:0];
    if (sz == 2'd0)      exp_load = uns ? {24'h0, b} : {{24{b[7]}}, b};
    else if (sz == 2'd1) exp_load = uns ? {16'h0, h} : {{16{h[15]}}, h};
    else                 exp_load = w;
  endfunction

  initial begin
    logic [31:0] data;
    int idx;
    int off;
    logic [1:0] sz;
    logic uns;
    Reset = 1'b1; Req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Size = 2'b00;
    unSigned = 1'b0; MemtoReg = 1'b0; Address = 32'd0; WriteData = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_result", Result, 32'd0);
    check("rst_done", {31'b0, Done}, 32'd0);
    check("rst_stall", {31'b0, Stall}, 32'd0);
    check("rst_addr_err", {31'b0, AddrErr}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    Reset = 1'b0;

    st(2'b10, 32'h20, 32'h0);
    st(2'b10, 32'h10, 32'hDEAD_BEEF);
    ld(2'b10, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    st(2'b00, 32'h11, 32'h0000_00A5);
    ld(2'b00, 1'b0, 1'b1, 32'h11, 32'hFFFF_FFA5);
    ld(2'b10, 1'b0, 1'b1, 32'h10, 32'hDEAD_A5EF);
    ld(2'b01, 1'b1, 1'b1, 32'h12, 32'h0000_DEAD);
    // misaligned half load and word store: error, no memory effect
    wait_idle();
    send(1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 32'h13, 32'd0, 32'd0, 1'b1, 1, 0, 1'b1);
    wait_idle();
    send(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h12, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 0, 1'b1);
    ld(2'b10, 1'b0, 1'b1, 32'h10, 32'hDEAD_A5EF);
    ld(2'b11, 1'b0, 1'b1, 32'h10, 32'hDEAD_A5EF);
    ld(2'b10, 1'b0, 1'b0, 32'h10, 32'h0000_0010);
    st(2'b01, 32'h10, 32'hFFFF_1234);
    ld(2'b01, 1'b0, 1'b1, 32'h12, 32'hFFFF_DEAD);
    ld(2'b01, 1'b0, 1'b1, 32'h10, 32'h0000_1234);
    ld(2'b00, 1'b0, 1'b1, 32'h13, 32'hFFFF_FFDE);
    ld(2'b00, 1'b1, 1'b1, 32'h12, 32'h0000_00AD);
    // MemWrite wins over MemRead
    wait_idle();
    send(1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 32'h14, 32'h1122_3344, 32'h14, 1'b0, 1, 0, 1'b1);
    ld(2'b10, 1'b0, 1'b1, 32'h14, 32'h1122_3344);

    // reset in the middle of a halfword store
    wait_idle();
    send(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h20, 32'h1234, 32'd0, 1'b0, 0, 0, 1'b0);
`ifndef MEM_BYTE_ENABLE_EN
    check("mid_store_stall", {31'b0, Stall}, 32'd1);
`endif
    Reset = 1'b1;
    @(posedge clk);
    #1;
    Reset = 1'b0;
    check("abort_result", Result, 32'd0);
    check("abort_done", {31'b0, Done}, 32'd0);
    check("abort_stall", {31'b0, Stall}, 32'd0);
    check("abort_addr_err", {31'b0, AddrErr}, 32'd0);
    check("abort_state", {30'b0, dbg_state}, 32'd0);
    ld(2'b10, 1'b0, 1'b1, 32'h20, RST_LOAD);

    // address wrap modulo depth
    st(2'b10, 32'h40, 32'hCAFE_F00D);
    ld(2'b10, 1'b0, 1'b1, 32'h00, 32'hCAFE_F00D);
    ld(2'b10, 1'b0, 1'b1, 32'h8000_0000, 32'hCAFE_F00D);

    // back-to-back pass-through
    wait_idle();
    for (int i = 1; i <= 3; i++)
      send(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 32'(i), 32'd0, 32'(i), 1'b0, 1, 0, 1'b1);

    // random word store then sized load of the same word
    for (int i = 0; i < 8; i++) begin
      idx  = $urandom_range(9, 15);
      data = $urandom;
      sz   = 2'($urandom_range(0, 2));
      off  = (sz == 2'd0) ? $urandom_range(0, 3) : (sz == 2'd1) ? 2 * $urandom_range(0, 1) : 0;
      uns  = 1'($urandom_range(0, 1));
      st(2'b10, 32'(idx * 4), data);
      ld(sz, uns, 1'b1, 32'(idx * 4 + off), exp_load(data, sz, 2'(off), uns));
    end

    wait_idle();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised MEM-stage block for the SAD pipeline.
- Contains:
  - word-addressed data memory with a configurable read latency;
  - byte, halfword and word loads with sign or zero extension;
  - byte, halfword and word stores, using read-modify-write when a store is partial;
  - writeback selection between load data and the ALU result.
- A small FSM sequences multi-cycle accesses and drives a Stall back to the pipeline. Done pulses when Result is valid.

Parameters:
- ADDR_WIDTH, 10, word-address bits; memory depth = 2**ADDR_WIDTH 32-bit words.
- READ_LAT, 1, memory read latency in cycles; legal range 1..4.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req  in  1  request valid; sampled only in IDLE or RESP.
- MemRead  in  1  load request.
- MemWrite  in  1  store request; takes priority over MemRead.
- Size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- unSigned  in  1  loads: 1 zero-extends, 0 sign-extends.
- MemtoReg  in  1  1 selects load data for Result; 0 selects Address.
- Address  in  32  byte address (ALU result).
- WriteData  in  32  store data (rt); byte/half data taken from the low bits.
- Result  out  32  writeback value, registered; valid while Done=1.
- Done  out  1  one-cycle completion pulse.
- Stall  out  1  high while a multi-cycle access is in flight.
- AddrErr  out  1  misaligned access flag, valid with Done.

Behaviour:
- Reset:
  - FSM returns to IDLE; Result=0, Done=0, Stall=0, AddrErr=0.
  - Memory contents are not cleared.
  - Reset during WAIT or WRITE aborts the access; a partial-store write not yet performed never happens.
- Addressing and byte order:
  - Word index = Address[ADDR_WIDTH+1:2]. Higher address bits are ignored, so accesses wrap modulo depth.
  - Little-endian lanes: lane k = bits 8k+7:8k, selected by Address[1:0].
  - Halfword lane = Address[1].
- Alignment:
  - Halfword with Address[0]=1, or word with Address[1:0]!=0, is misaligned.
  - Misaligned access: no memory access; next cycle RESP with Done=1, AddrErr=1, Result=0.
- FSM states: IDLE, WAIT, WRITE, RESP.
- Request acceptance:
  - A request is accepted on a rising edge when Req=1 in IDLE or RESP.
  - All inputs are latched at acceptance; inputs are don't-care afterwards.
  - Done falls after RESP unless a new request is accepted in that same cycle (back-to-back requests allowed).
- Pass-through (MemRead=MemWrite=0):
  - Next cycle RESP; Result = Address regardless of MemtoReg.
- Word store: memory written at the accept edge; next cycle RESP, Result = Address.
- Load:
  - Read issued at accept; WAIT for READ_LAT cycles with Stall=1; then RESP.
  - Done occurs READ_LAT+1 cycles after accept.
  - Extension: the selected byte/half is extended per unSigned.
  - Result = extended load data if MemtoReg=1, else Address.
- Partial store:
  1. Read issued at accept.
  2. WAIT for READ_LAT cycles.
  3. WRITE, one cycle: merge WriteData into the addressed lane(s) and write the whole word back.
  4. RESP.
  - Done occurs READ_LAT+2 cycles after accept; Stall=1 in WAIT and WRITE; Result = Address.
- Stall: Stall=1 exactly in WAIT and WRITE; 0 in IDLE and RESP.
- Cycle counter: a READ_LAT counter reloads on entering WAIT. READ_LAT=1 gives exactly one WAIT cycle.

Optional Feature:
- Macro: MEM_BYTE_ENABLE_EN.
- When defined:
  - Memory has per-lane write enables.
  - Byte and halfword stores complete like word stores: write at accept, RESP next cycle, no WAIT/WRITE, Stall never asserted for stores.
  - The WRITE state is unreachable.
- When undefined: partial stores use read-modify-write exactly as described in Behaviour.

Test Plan:
- Reset, then word store 0xDEADBEEF at 0x10, then load word at 0x10 with MemtoReg=1 (READ_LAT=2) -> Stall high 2 cycles, Done 3 cycles after accept, Result=0xDEADBEEF.
- After the above, byte store 0xA5 at 0x11, then load byte 0x11 with unSigned=0 -> Result=0xFFFFFFA5. Load word 0x10 -> 0xDEADA5EF.
- Halfword load at 0x12 with unSigned=1 on word 0xDEADA5EF -> Result=0x0000DEAD. Halfword load at 0x13 -> AddrErr=1, Result=0, Done next cycle, memory unchanged.
- Partial store without MEM_BYTE_ENABLE_EN and READ_LAT=1 -> Stall high exactly 2 cycles, Done at accept+3. With the macro defined -> Stall never high, Done at accept+1.
- Reset asserted during the WAIT of a halfword store of 0x1234 to 0x20 holding 0 -> outputs return to reset values; subsequent load of 0x20 returns 0.
- With ADDR_WIDTH=4, word store to 0x40 then load from 0x00 -> same data (wrap). Back-to-back pass-through requests with Address 1, 2, 3 -> Done high three consecutive cycles, Result 1, 2, 3.
